// File: rtl/ahb_stream_sink_pkg.sv
// Shared constants for ahb_stream_sink: AHB codes, register map, STATUS bit
// positions and data-phase state encodings.
package ahb_stream_sink_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Register offsets as decoded from HADDR[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_EMPTY_BIT   = 16;
    localparam int STAT_FULL_BIT    = 17;
    localparam int STAT_OVF_BIT     = 18;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'd0,
        DP_WDATA = 2'd1,
        DP_REG   = 2'd2,
        DP_ERR   = 2'd3
    } dp_state_e;

    function automatic logic htrans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with push, pop, flush and occupancy count; head entry is
// presented combinationally from the storage array (first-word fall-through).
module fifo_sync #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = count_q[DEPTH_LOG2];
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        if (do_push && !do_pop)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ahb_stream_sink.sv
// AHB write slave feeding a 32-bit valid/ready stream through a FIFO.
// Define AHB_STREAM_SINK_ERR_ON_FULL_EN to answer full-FIFO writes with ERROR instead of wait states.
module ahb_stream_sink
    import ahb_stream_sink_pkg::*;
#(
    parameter int DEPTH_LOG2     = 4,
    parameter int ADDR_LSB_WIDTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA
);
    dp_state_e           state_q, state_d;
    logic [1:0]          addr_q, addr_d;
    logic                write_q, write_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                push, pop, flush, full, empty;
    logic                accept, blocked, ctrl_wr;
    logic [DEPTH_LOG2:0] count;
    logic [31:0]         status;
    logic                unused_bits;

    fifo_sync #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .push_data (HWDATA),
        .pop       (pop),
        .flush     (flush),
        .rd_data   (OUT_DATA),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign unused_bits = ^{HSIZE, HBURST, HADDR[31:ADDR_LSB_WIDTH], HADDR[1:0]};

    assign OUT_VALID = !empty;
    assign pop       = OUT_VALID & OUT_READY;
    assign accept    = HSEL & HREADYin & htrans_active(HTRANS);
    // A DATA write can complete while full only if the head drains this same cycle
    assign blocked   = (state_q == DP_WDATA) & full & !pop;
    assign push      = (state_q == DP_WDATA) & !blocked;
    assign ctrl_wr   = (state_q == DP_REG) & write_q & (addr_q == REG_CONTROL);
    assign flush     = ctrl_wr & HWDATA[CTRL_FLUSH_BIT];
    assign HRDATA    = rdata_q;

`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (blocked) ovf_d = 1'b1;
        if (ctrl_wr && HWDATA[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
`endif

    always_comb begin
        status = '0;
        status[DEPTH_LOG2:0]   = count;
        status[STAT_EMPTY_BIT] = empty;
        status[STAT_FULL_BIT]  = full;
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
        status[STAT_OVF_BIT]   = ovf_q;
`endif
    end

    always_comb begin
        HREADYout = !blocked;
        HRESP     = HRESP_OKAY;
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
        // First error cycle holds HREADYout low, second releases it
        if (blocked || state_q == DP_ERR) HRESP = HRESP_ERROR;
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        rdata_d = '0;
        if (HREADYin) begin
            state_d = DP_IDLE;
            if (accept) begin
                addr_d  = HADDR[3:2];
                write_d = HWRITE;
                state_d = (HWRITE && HADDR[3:2] == REG_DATA) ? DP_WDATA : DP_REG;
                if (!HWRITE && HADDR[3:2] == REG_STATUS) rdata_d = status;
            end
        end
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
        if (blocked) state_d = DP_ERR;
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= DP_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ahb_stream_sink.sv
// Self-checking bench for ahb_stream_sink: directed scenarios plus randomized
// bus and stream traffic compared every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_ahb_stream_sink;
    import ahb_stream_sink_pkg::*;

    localparam int DEPTH = 16;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = HTRANS_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [2:0]  HBURST = 3'b000;
    logic [31:0] HWDATA = '0;
    logic        HREADYin;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADYout;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_DATA;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 3;

    assign HREADYin = HREADYout;
    always #5 HCLK = ~HCLK;

    ahb_stream_sink dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADYin  (HREADYin),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .HREADYout (HREADYout),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: stream contents as a queue, one pending data phase
    typedef enum int {K_NONE, K_DWR, K_RD, K_CWR, K_OWR, K_ERR2} kind_e;
    logic [31:0] mq[$];
    kind_e       dp = K_NONE;
    logic [31:0] exp_rdata = '0;
    logic        ovf = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] last_pop = '0;

    function automatic logic [31:0] status_word(input int n, input logic o);
        int s;
        s = n;
        if (n == 0) s += 32'h0001_0000;
        if (n == DEPTH) s += 32'h0002_0000;
        if (o) s += 32'h0004_0000;
        return 32'(s);
    endfunction

    always @(negedge HCLK) begin : model
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic        popping;
        logic [31:0] st;
        e_rdy = 1'b1;
        e_resp = HRESP_OKAY;
        popping = 1'b0;
        if (chk_en) begin
            popping = OUT_READY && (mq.size() > 0);
            if (dp == K_DWR && mq.size() >= DEPTH && !popping) begin
                e_rdy = 1'b0;
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
                e_resp = HRESP_ERROR;
`endif
            end
            if (dp == K_ERR2) e_resp = HRESP_ERROR;
            check("hreadyout", 32'(HREADYout), 32'(e_rdy));
            check("hresp", 32'(HRESP), 32'(e_resp));
            check("out_valid", 32'(OUT_VALID), 32'(mq.size() > 0));
            if (mq.size() > 0) check("out_data", OUT_DATA, mq[0]);
            if (dp == K_RD) check("hrdata", HRDATA, exp_rdata);
            if (popping) last_pop = OUT_DATA;
        end
        if (HRESET) begin
            mq.delete();
            dp = K_NONE;
            ovf = 1'b0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            st = status_word(mq.size(), ovf);
            if (popping) void'(mq.pop_front());
            if (dp == K_DWR && e_rdy) mq.push_back(HWDATA);
            if (dp == K_CWR) begin
                if (HWDATA[CTRL_FLUSH_BIT]) mq.delete();
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
                if (HWDATA[CTRL_CLR_OVF_BIT]) ovf = 1'b0;
`endif
            end
            if (dp == K_DWR && !e_rdy) begin
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
                dp = K_ERR2;
                ovf = 1'b1;
`endif
            end else if (HSEL && e_rdy && HTRANS[1]) begin
                if (HWRITE) begin
                    if (HADDR[3:2] == REG_DATA) dp = K_DWR;
                    else if (HADDR[3:2] == REG_CONTROL) dp = K_CWR;
                    else dp = K_OWR;
                end else begin
                    dp = K_RD;
                    exp_rdata = (HADDR[3:2] == REG_STATUS) ? st : 32'h0;
                end
            end else begin
                dp = K_NONE;
            end
        end
    end

    // Stream consumer: 0 never, 1 always, 2 coin flip, 3 manual, 4 sparse
    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            case (rdy_mode)
                0: OUT_READY = 1'b0;
                1: OUT_READY = 1'b1;
                2: OUT_READY = ($urandom_range(0, 1) == 1);
                4: OUT_READY = ($urandom_range(0, 4) == 0);
                default: ;
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic ahb_xfer(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int waits, output int errs);
        logic r;
        int   n;
        waits = 0;
        errs = 0;
        rdata = '0;
        HSEL = sel;
        HTRANS = trans;
        HADDR = addr;
        HWRITE = wr;
        n = 0;
        do begin
            @(negedge HCLK);
            r = HREADYout;
            @(posedge HCLK);
            #1;
            n++;
        end while (!r && n < 64);
        HSEL = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWDATA = wdata;
        if (r) begin
            n = 0;
            do begin
                @(negedge HCLK);
                r = HREADYout;
                rdata = HRDATA;
                if (HRESP == HRESP_ERROR) errs++;
                @(posedge HCLK);
                #1;
                n++;
                if (!r) waits++;
            end while (!r && n < 64);
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: addr 0x%08h still not ready after %0d cycles", addr, n);
        end
    endtask

    task automatic wr_data(input logic [31:0] d, output int waits);
        logic [31:0] rd;
        int e;
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h4000_0000, d, rd, waits, e);
    endtask

    task automatic rd_status(output logic [31:0] rd);
        int w, e;
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h4000_0004, 32'h0, rd, w, e);
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        logic [31:0] rd;
        int w, e;
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h4000_0008, d, rd, w, e);
    endtask

    task automatic drain();
        rdy_mode = 1;
        cyc(24);
        rdy_mode = 3;
        OUT_READY = 1'b0;
        cyc(1);
    endtask

    task automatic fill16();
        int w;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data(32'h100 + 32'(i), w);
            check("fill_waits", 32'(w), 32'd0);
        end
    endtask

    initial begin : main
        logic [31:0] rd;
        int w, e;
        cyc(3);
        check("rst_hreadyout", 32'(HREADYout), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'(HRESP_OKAY));
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_data", OUT_DATA, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESET = 1'b0;
        cyc(1);
        rd_status(rd);
        check("status_after_reset", rd, 32'h0001_0000);

        // Three single writes, then drain back to back
        wr_data(32'h11, w); check("w11_waits", 32'(w), 32'd0);
        wr_data(32'h22, w); check("w22_waits", 32'(w), 32'd0);
        wr_data(32'h33, w); check("w33_waits", 32'(w), 32'd0);
        rd_status(rd);
        check("status_count3", rd, 32'h0000_0003);
        check("head_0x11", OUT_DATA, 32'h11);
        OUT_READY = 1'b1;
        check("drain0", OUT_DATA, 32'h11);
        cyc(1); check("drain1", OUT_DATA, 32'h22);
        cyc(1); check("drain2", OUT_DATA, 32'h33);
        cyc(1); check("drained_empty", 32'(OUT_VALID), 32'd0);
        OUT_READY = 1'b0;
        cyc(1);

        // Seventeenth write against a full FIFO
        fill16();
        rd_status(rd);
        check("status_full16", rd, 32'h0002_0010);
`ifdef AHB_STREAM_SINK_ERR_ON_FULL_EN
        ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0, 32'hDEAD, rd, w, e);
        check("err_waits", 32'(w), 32'd1);
        check("err_resp_cycles", 32'(e), 32'd2);
        rd_status(rd);
        check("status_ovf", rd, 32'h0006_0010);
        wr_ctrl(32'h2);
        rd_status(rd);
        check("status_ovf_cleared", rd, 32'h0002_0010);
        drain();
        check("last_word_err", last_pop, 32'h10F);
`else
        fork
            ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0, 32'hDEAD, rd, w, e);
            begin
                repeat (6) @(posedge HCLK);
                #1;
                OUT_READY = 1'b1;
                @(posedge HCLK);
                #1;
                OUT_READY = 1'b0;
            end
        join
        check("stall_waits", 32'(w), 32'd5);
        check("stall_no_error", 32'(e), 32'd0);
        rd_status(rd);
        check("status_full_after_stall", rd, 32'h0002_0010);
        drain();
        check("last_word_dead", last_pop, 32'hDEAD);
`endif

        // Full FIFO with the consumer draining during the data phase
        fill16();
        fork
            ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0, 32'hBEEF, rd, w, e);
            begin
                @(posedge HCLK);
                #1;
                OUT_READY = 1'b1;
                @(posedge HCLK);
                #1;
                OUT_READY = 1'b0;
            end
        join
        check("pushpop_full_waits", 32'(w), 32'd0);
        rd_status(rd);
        check("pushpop_full_count", rd, 32'h0002_0010);
        drain();
        check("last_word_beef", last_pop, 32'hBEEF);

        // Flush with five entries held
        for (int i = 0; i < 5; i++) wr_data(32'hA0 + 32'(i), w);
        rd_status(rd);
        check("status_count5", rd, 32'h0000_0005);
        wr_ctrl(32'h1);
        check("flush_out_valid", 32'(OUT_VALID), 32'd0);
        rd_status(rd);
        check("status_after_flush", rd, 32'h0001_0000);
        wr_data(32'hCAFE, w);
        check("post_flush_valid", 32'(OUT_VALID), 32'd1);
        check("post_flush_data", OUT_DATA, 32'hCAFE);
        drain();

        // Reset while a write is pending against a full FIFO
        fill16();
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0; HWRITE = 1'b1;
        cyc(1);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hBAD;
        cyc(3);
        HRESET = 1'b1;
        cyc(1);
        HRESET = 1'b0;
        check("midstall_rst_ready", 32'(HREADYout), 32'd1);
        check("midstall_rst_valid", 32'(OUT_VALID), 32'd0);
        rd_status(rd);
        check("midstall_rst_status", rd, 32'h0001_0000);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int unsigned r;
            logic [31:0] hi;
            rdy_mode = (it < 200) ? 4 : 2;
            r = $urandom_range(0, 99);
            hi = $urandom & 32'hFFFF_FFF0;
            if (r < 55)
                ahb_xfer(1'b1, ($urandom_range(0, 1) == 1) ? HTRANS_SEQ : HTRANS_NONSEQ, 1'b1,
                         hi, $urandom, rd, w, e);
            else if (r < 65)
                ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b0, hi | 32'h4, 32'h0, rd, w, e);
            else if (r < 70)
                ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b0, hi, 32'h0, rd, w, e);
            else if (r < 75)
                ahb_xfer(1'b1, HTRANS_NONSEQ, ($urandom_range(0, 1) == 1), hi | {28'h0, REG_RSVD, 2'b00},
                         $urandom, rd, w, e);
            else if (r < 80)
                ahb_xfer(1'b1, HTRANS_NONSEQ, 1'b1, hi | 32'h8,
                         ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h2, rd, w, e);
            else if (r < 85)
                ahb_xfer(1'b0, HTRANS_NONSEQ, 1'b1, hi, $urandom, rd, w, e);
            else if (r < 90)
                ahb_xfer(1'b1, HTRANS_BUSY, 1'b1, hi, $urandom, rd, w, e);
            else
                cyc($urandom_range(1, 3));
        end
        rdy_mode = 3;
        OUT_READY = 1'b0;
        drain();
        check("final_empty", 32'(OUT_VALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
